// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix entry path.
//   - LOC_xx   : location codes produced by the location-select counter
//   - DW_DEFAULT : default matrix element width
//   - state_t  : entry FSM states (FILL while collecting, READY while presenting)
//   - decode_loc : location code -> {legal flag, 2-bit element index}
package matrix_pkg;

  localparam int DW_DEFAULT = 8;

  localparam logic [3:0] LOC_00 = 4'ha;
  localparam logic [3:0] LOC_01 = 4'hb;
  localparam logic [3:0] LOC_10 = 4'hc;
  localparam logic [3:0] LOC_11 = 4'hd;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } loc_dec_t;

  // Element index is row*2+col, which lines up with the a_flat/b_flat packing.
  function automatic loc_dec_t decode_loc(input logic [3:0] loc);
    loc_dec_t dec;
    dec.legal = 1'b1;
    dec.idx   = 2'd0;
    case (loc)
      LOC_00:  dec.idx = 2'd0;
      LOC_01:  dec.idx = 2'd1;
      LOC_10:  dec.idx = 2'd2;
      LOC_11:  dec.idx = 2'd3;
      default: dec.legal = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/matrix_entry_writer_rise_detect.sv
// rise_detect: single-flop rising-edge detector for an already synchronous,
// debounced level.
//   clk   : system clock
//   btnC  : asynchronous active-low reset
//   in    : level input
//   pulse : high for the one cycle where in is high and was low last cycle
// The history flop resets to 0, so a level that is already high when reset
// releases produces one pulse.
module rise_detect (
  input  logic clk,
  input  logic btnC,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      prev <= 1'b0;
    end else begin
      prev <= in;
    end
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/matrix_entry_writer.sv
// matrix_entry_writer: captures 2x2 operand matrices A and B element by
// element and hands them to the multiplier with a ready/ack handshake.
//   clk        : system clock
//   btnC       : asynchronous active-low reset
//   matrix_loc : location code, 4'ha..4'hd select element (0,0)..(1,1)
//   mat_sel    : 0 writes matrix A, 1 writes matrix B
//   sw_data    : element value
//   btnEnter   : enter level; each rising edge is one write request
//   mult_ack   : multiplier has consumed the operands
//   a_flat     : matrix A, element k = row*2+col at [k*DW +: DW]
//   b_flat     : matrix B, same packing
//   valid_mask : [3:0] A elements written, [7:4] B elements written
//   mats_ready : all eight elements written, operands held stable
//   loc_err    : sticky flag, an enter was seen with an illegal location
// All outputs come straight from flops.
module matrix_entry_writer
  import matrix_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            btnC,
  input  logic [3:0]      matrix_loc,
  input  logic            mat_sel,
  input  logic [DW-1:0]   sw_data,
  input  logic            btnEnter,
  input  logic            mult_ack,
  output logic [4*DW-1:0] a_flat,
  output logic [4*DW-1:0] b_flat,
  output logic [7:0]      valid_mask,
  output logic            mats_ready,
  output logic            loc_err
);

  state_t          state;
  state_t          next_state;
  logic [4*DW-1:0] next_a;
  logic [4*DW-1:0] next_b;
  logic [7:0]      next_mask;
  logic            next_err;
  logic            strobe;
  loc_dec_t        dec;

  rise_detect u_enter_edge (
    .clk   (clk),
    .btnC  (btnC),
    .in    (btnEnter),
    .pulse (strobe)
  );

  assign dec = decode_loc(matrix_loc);

  // State and all datapath registers share one reset so that an abort in the
  // middle of a fill leaves nothing half-written behind.
  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      state      <= FILL;
      a_flat     <= '0;
      b_flat     <= '0;
      valid_mask <= '0;
      loc_err    <= 1'b0;
    end else begin
      state      <= next_state;
      a_flat     <= next_a;
      b_flat     <= next_b;
      valid_mask <= next_mask;
      loc_err    <= next_err;
    end
  end

  // In READY only the ack matters, which keeps the operands frozen while the
  // multiplier reads them and means an ack always wins over a same-cycle
  // strobe. The mask bit index is {mat_sel, idx} so B lands in the upper nibble.
  always_comb begin
    next_state = state;
    next_a     = a_flat;
    next_b     = b_flat;
    next_mask  = valid_mask;
    next_err   = loc_err;
    case (state)
      FILL: begin
        if (strobe) begin
          if (dec.legal) begin
            if (mat_sel) begin
              next_b[dec.idx*DW +: DW] = sw_data;
            end else begin
              next_a[dec.idx*DW +: DW] = sw_data;
            end
            next_mask[{mat_sel, dec.idx}] = 1'b1;
          end else begin
            next_err = 1'b1;
          end
        end
        if (next_mask == 8'hFF) begin
          next_state = READY;
        end
      end
      READY: begin
        if (mult_ack) begin
          next_state = FILL;
          next_mask  = '0;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // The state flop is the only source, so ready cannot glitch with inputs.
  assign mats_ready = (state == READY);

endmodule

// File: tb/tb_matrix_entry_writer.sv
// Testbench for matrix_entry_writer: directed scenarios plus a random phase,
// checked every cycle against an element-array model of the entry rules.
module tb_matrix_entry_writer;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            btnC = 1'b1;
  logic [3:0]      matrix_loc = 4'h0;
  logic            mat_sel = 1'b0;
  logic [DW-1:0]   sw_data = '0;
  logic            btnEnter = 1'b0;
  logic            mult_ack = 1'b0;
  logic [4*DW-1:0] a_flat;
  logic [4*DW-1:0] b_flat;
  logic [7:0]      valid_mask;
  logic            mats_ready;
  logic            loc_err;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  // Reference model: element arrays and per-element written flags.
  logic [DW-1:0] m_a [4];
  logic [DW-1:0] m_b [4];
  bit            w_a [4];
  bit            w_b [4];
  bit            m_ready;
  bit            m_err;
  bit            m_prev;

  matrix_entry_writer #(.DW(DW)) dut (
    .clk        (clk),
    .btnC       (btnC),
    .matrix_loc (matrix_loc),
    .mat_sel    (mat_sel),
    .sw_data    (sw_data),
    .btnEnter   (btnEnter),
    .mult_ack   (mult_ack),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .valid_mask (valid_mask),
    .mats_ready (mats_ready),
    .loc_err    (loc_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model follows the written rules directly: a request is an enter that was
  // low last cycle; READY ignores requests and only listens to ack.
  always @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      for (int k = 0; k < 4; k++) begin
        m_a[k] = '0; m_b[k] = '0; w_a[k] = 0; w_b[k] = 0;
      end
      m_ready = 0; m_err = 0; m_prev = 0;
    end else begin
      bit req;
      req = btnEnter && !m_prev;
      m_prev = btnEnter;
      if (m_ready) begin
        if (mult_ack) begin
          m_ready = 0;
          for (int k = 0; k < 4; k++) begin
            w_a[k] = 0; w_b[k] = 0;
          end
        end
      end else if (req) begin
        if (matrix_loc >= 4'ha && matrix_loc <= 4'hd) begin
          int k;
          k = int'(matrix_loc) - 10;
          if (mat_sel) begin
            m_b[k] = sw_data; w_b[k] = 1;
          end else begin
            m_a[k] = sw_data; w_a[k] = 1;
          end
          m_ready = 1;
          for (int j = 0; j < 4; j++) begin
            if (!w_a[j] || !w_b[j]) m_ready = 0;
          end
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4*DW-1:0] ea;
      logic [4*DW-1:0] eb;
      logic [7:0]      em;
      for (int k = 0; k < 4; k++) begin
        ea[k*DW +: DW] = m_a[k];
        eb[k*DW +: DW] = m_b[k];
        em[k]          = w_a[k];
        em[k+4]        = w_b[k];
      end
      checkOutput("model_a_flat", 64'(a_flat), 64'(ea));
      checkOutput("model_b_flat", 64'(b_flat), 64'(eb));
      checkOutput("model_mask", 64'(valid_mask), 64'(em));
      checkOutput("model_ready", 64'(mats_ready), 64'(m_ready));
      checkOutput("model_err", 64'(loc_err), 64'(m_err));
    end
  end

  task automatic applyStimulus(input logic [3:0] loc, input logic sel, input logic [DW-1:0] data,
                               input logic enter, input logic ack);
    @(posedge clk);
    #2;
    matrix_loc = loc;
    mat_sel    = sel;
    sw_data    = data;
    btnEnter   = enter;
    mult_ack   = ack;
  endtask

  task automatic strobe(input logic [3:0] loc, input logic sel, input logic [DW-1:0] data);
    applyStimulus(loc, sel, data, 1'b1, 1'b0);
    applyStimulus(loc, sel, data, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"}, 64'(a_flat), 64'h0);
    checkOutput({tag, "_b"}, 64'(b_flat), 64'h0);
    checkOutput({tag, "_mask"}, 64'(valid_mask), 64'h0);
    checkOutput({tag, "_ready"}, 64'(mats_ready), 64'h0);
    checkOutput({tag, "_err"}, 64'(loc_err), 64'h0);
  endtask

  initial begin
    #1 btnC = 1'b0;
    #3;
    checkAllZero("reset");
    @(posedge clk); #2 btnC = 1'b1;
    cmp_en = 1'b1;

    // Fill A = 1..4, B = 5..7, last B element checked around the completing edge.
    for (int k = 0; k < 4; k++) strobe(4'(10 + k), 1'b0, 8'(k + 1));
    for (int k = 0; k < 3; k++) strobe(4'(10 + k), 1'b1, 8'(k + 5));
    applyStimulus(4'hd, 1'b1, 8'h08, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ready_before_8th", 64'(mats_ready), 64'h0);
    applyStimulus(4'hd, 1'b1, 8'h08, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ready_after_8th", 64'(mats_ready), 64'h1);
    checkOutput("fill_a", 64'(a_flat), 64'h04030201);
    checkOutput("fill_b", 64'(b_flat), 64'h08070605);
    checkOutput("fill_mask", 64'(valid_mask), 64'hFF);

    // Strobe in READY is ignored; then ack with a simultaneous strobe.
    strobe(4'ha, 1'b0, 8'hFF);
    @(negedge clk);
    checkOutput("ready_strobe_a", 64'(a_flat), 64'h04030201);
    applyStimulus(4'ha, 1'b0, 8'hFF, 1'b1, 1'b1);
    applyStimulus(4'ha, 1'b0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ack_ready", 64'(mats_ready), 64'h0);
    checkOutput("ack_mask", 64'(valid_mask), 64'h0);
    checkOutput("ack_a", 64'(a_flat), 64'h04030201);

    // Held enter produces one write.
    for (int i = 0; i < 20; i++) applyStimulus(4'ha, 1'b0, 8'h11, 1'b1, 1'b0);
    applyStimulus(4'ha, 1'b0, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("held_mask", 64'(valid_mask), 64'h01);
    checkOutput("held_a", 64'(a_flat), 64'h04030211);

    // Illegal code, then overwrite of (0,1) twice.
    strobe(4'h3, 1'b0, 8'h55);
    @(negedge clk);
    checkOutput("illegal_err", 64'(loc_err), 64'h1);
    checkOutput("illegal_mask", 64'(valid_mask), 64'h01);
    checkOutput("illegal_a", 64'(a_flat), 64'h04030211);
    strobe(4'hb, 1'b0, 8'h22);
    strobe(4'hb, 1'b0, 8'h33);
    @(negedge clk);
    checkOutput("overwrite_elem", 64'(a_flat[15:8]), 64'h33);
    checkOutput("overwrite_mask", 64'(valid_mask), 64'h03);
    checkOutput("overwrite_ready", 64'(mats_ready), 64'h0);
    checkOutput("sticky_err", 64'(loc_err), 64'h1);

    // Reach mask 0F, then asynchronous reset between edges.
    strobe(4'hc, 1'b0, 8'h44);
    strobe(4'hd, 1'b0, 8'h66);
    @(negedge clk);
    checkOutput("midfill_mask", 64'(valid_mask), 64'h0F);
    @(posedge clk); #3;
    btnC = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(posedge clk); #2 btnC = 1'b1;

    // Fresh random-data fill in a shuffled order.
    begin
      int order [8];
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 8; i++)
        strobe(4'(10 + order[i] % 4), order[i] >= 4, 8'($urandom));
    end
    @(negedge clk);
    checkOutput("refill_ready", 64'(mats_ready), 64'h1);
    checkOutput("refill_mask", 64'(valid_mask), 64'hFF);

    // Random phase: mostly legal codes, random enter/ack toggling.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] loc;
      loc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(10, 13)) : 4'($urandom);
      applyStimulus(loc, 1'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 4) == 0);
    end
    applyStimulus(4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/matrix_entry_writer.md
# matrix_entry_writer

Receiving end of the matrix location-select path. Decodes the 4-bit location code (4'ha–4'hd) to a 2x2 element index and captures operand values on a debounced enter button into matrix A or B. Tracks which of the 8 elements have been written, and presents both matrices to the multiplier with a ready/ack handshake.

## Interface
Parameters:
- DW, 8, element width in bits

Ports:
- clk  in  1  system clock
- btnC  in  1  asynchronous active-low reset
- matrix_loc  in  4  location code; 4'ha=(0,0), 4'hb=(0,1), 4'hc=(1,0), 4'hd=(1,1)
- mat_sel  in  1  0 = write matrix A, 1 = write matrix B
- sw_data  in  DW  element value from switches
- btnEnter  in  1  debounced, synchronous enter level
- mult_ack  in  1  multiplier has consumed the operands
- a_flat  out  4*DW  matrix A, element k at [k*DW +: DW], k = row*2+col
- b_flat  out  4*DW  matrix B, same packing
- valid_mask  out  8  bits [3:0] = A elements written, bits [7:4] = B elements written
- mats_ready  out  1  all 8 elements written, operands stable
- loc_err  out  1  sticky: enter was seen with an illegal matrix_loc

## Operation
- Write strobe = rising edge of btnEnter. Edge detection uses a registered copy of btnEnter.
  - Held level produces exactly one write.
  - Edge register resets to 0, so btnEnter high out of reset counts as an edge.
- FSM states:
  - FILL: on strobe with a legal code, write sw_data to element index of the selected matrix and set the matching valid_mask bit.
    - Rewriting an element overwrites the data; its mask bit stays 1.
    - On strobe with an illegal code (not a–d): no write, no mask change, set loc_err.
    - When the mask becomes 8'hFF, go to READY.
  - READY: mats_ready=1.
    - Strobes are ignored: no write, no loc_err.
    - mult_ack=1 → FILL and valid_mask cleared to 0. a_flat/b_flat keep their values.
- Simultaneous strobe and mult_ack in READY: ack is taken, strobe dropped.
- mult_ack in FILL: ignored.
- loc_err clears only on reset.
- Reset (asynchronous, any state, mid-fill included), all outputs go low:
  - state=FILL
  - a_flat=0, b_flat=0
  - valid_mask=0
  - mats_ready=0, loc_err=0
  - edge register=0

## Timing
- Strobe detected at clk edge n: element and mask bit update at edge n; visible in cycle n+1.
- Completing (8th distinct) write at edge n: mats_ready=1 from cycle n+1. mats_ready is registered, not derived combinationally from the mask.
- mult_ack sampled high at edge m in READY: mats_ready=0 and valid_mask=0 from cycle m+1.
- Earliest legal write after ack: next strobe edge ≥ m+1.
- a_flat/b_flat are stable for the whole time mats_ready=1.
- loc_err asserts the cycle after the offending strobe.
- No combinational path from any input to any output.

## Structure
- Shared package matrix_pkg:
  - LOC_00=4'ha, LOC_01=4'hb, LOC_10=4'hc, LOC_11=4'hd, shared with the location-select counter
  - default DW
  - FSM state encoding (FILL, READY)
- Sub-module rise_detect (clk, btnC, in, pulse): a single-flop edge detector, reusable for other buttons.
- Decode of matrix_loc to 2-bit index plus legal flag is a combinational function in the package.

## Test plan
- Reset then 8 strobes: A = 1,2,3,4 at a–d with mat_sel=0; B = 5,6,7,8 at a–d with mat_sel=1.
  - Expect a_flat=32'h04030201, b_flat=32'h08070605, valid_mask=8'hFF.
  - Expect mats_ready=1 exactly one cycle after the 8th strobe.
- btnEnter held high 20 cycles at loc 4'ha, sw_data=8'h11: exactly one write, valid_mask=8'h01.
- Strobe with matrix_loc=4'h3: loc_err=1 next cycle, valid_mask and a_flat unchanged. A later legal write still works and loc_err stays 1.
- In READY, strobe with sw_data=8'hFF at 4'ha:
  - a_flat unchanged.
  - mult_ack asserted with another strobe in the same cycle → next cycle mats_ready=0, valid_mask=0, a_flat unchanged.
- Overwrite 4'hb in A twice (8'h22, then 8'h33): a_flat[15:8]=8'h33, valid_mask bit1=1, still in FILL.
- Assert btnC low mid-fill (mask=8'h0F, asynchronously, between clk edges): all outputs 0 immediately. After release, a fresh 8-write sequence reaches READY normally.
